spi_memory_burst: RTL and testbench
===================================

Name: spi_memory_burst

Overview:
- Parametrised SPI-slave register memory; successor to the fixed 7-bit-address / 8-bit-data SPI memory.
- Adds configurable address and data widths, an input synchroniser/edge detector and an explicit reset.
- Adds an optional burst mode: address auto-increments (with wrap-around) while chip select stays low.
- Sits between the board SPI pins and the LED/status logic on the FPGA top level; SPI mode 0, MSB first.

Parameters:
- ADDR_WIDTH, 7: address bits per frame; memory depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8: bits per data word.
- BURST_EN, 1: 1 = auto-increment and continue while cs_pin is low; 0 = one word per frame, then ignore sclk until cs_pin rises.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- sclk_pin  in  1  SPI clock, asynchronous to clk.
- cs_pin  in  1  SPI chip select, active low, asynchronous.
- mosi_pin  in  1  SPI data in.
- miso_pin  out  1  SPI data out; 0 when not driving read data.
- miso_oe  out  1  high while in READ state (tristate enable for the top level).
- busy  out  1  high whenever the state is not IDLE.
- leds  out  4  low nibble of the last completed write word (zero-extended if DATA_WIDTH < 4).

Behaviour:
- Reset: async reset forces state=IDLE and clears shift registers, bit counter, address register, miso_pin=0, miso_oe=0, busy=0, leds=0, and all synchroniser flops (cs synchroniser to 1). Memory array contents are not reset.
- Input conditioning: sclk_pin, cs_pin and mosi_pin each pass through a 2-flop synchroniser. A rise/fall detect on the synchronised sclk yields single-cycle strobes.
  - A pin event takes effect 3 clk cycles after the pin edge.
  - Legal sclk high and low times are each at least 4 clk periods.
- States: IDLE, CMD, WRITE, READ, HOLD.
- IDLE: on synchronised cs falling edge -> CMD, bit counter=0.
- CMD: on each sclk rise, shift mosi into a command register (ADDR_WIDTH address bits MSB first, then 1 R/W bit).
  - On the rise capturing the R/W bit, latch the address.
  - R/W=0 -> WRITE.
  - R/W=1 -> READ; load mem[addr] into the tx shift register on the same cycle.
- WRITE: shift in DATA_WIDTH bits on sclk rises. On the rise capturing the last bit:
  - write mem[addr] <= word; leds <= word[3:0].
  - BURST_EN=1: addr <= addr+1 (mod 2**ADDR_WIDTH), stay in WRITE, counter=0.
  - BURST_EN=0: go to HOLD.
- READ: on each sclk fall, miso_pin <= tx MSB, then shift left.
  - The first fall after the R/W rise presents data bit DATA_WIDTH-1.
  - On the rise after the last bit has been presented:
    - BURST_EN=1: addr <= addr+1 (mod); reload tx from mem[addr+1] the same cycle so the next fall presents its MSB.
    - BURST_EN=0: go to HOLD.
  - mosi is ignored in READ.
- HOLD: sclk ignored; miso_pin=0.
- CS rule: synchronised cs rising in any state -> IDLE on the next clk, miso_pin=0, miso_oe=0.
  - An incomplete word is discarded; memory and leds are unchanged.
  - A completed word is never rolled back.
- sclk edges while cs is high (in IDLE) have no effect.
- A cs fall and an sclk edge in the same clk: the cs fall wins and the sclk edge is dropped.
- Address wrap: after the last address (all ones), a burst continues at 0.
- Read-after-write to the same address in a later frame returns the new data; a write takes effect on the capturing clk.

Test Plan:
- Single write then read (defaults): frame addr 0x6D, R/W=0, data 0xF0; new frame addr 0x0A, data 0x0F; read 0x6D -> miso serial 1,1,1,1,0,0,0,0 sampled after each sclk fall; read 0x0A -> 0,0,0,0,1,1,1,1; leds=4'hF after the second write.
- CS high: clock a full write of 0x55 to 0x6D with cs_pin=1 -> busy stays 0; a subsequent read of 0x6D still returns 0xF0.
- Burst write/read with wrap: cs low, addr 0x7E write, data 0x11,0x22,0x33 -> mem[0x7E]=0x11, mem[0x7F]=0x22, mem[0x00]=0x33; a burst read from 0x7E returns 0x11,0x22,0x33 back-to-back with no gap bits.
- Abort: write to 0x05 with cs raised after 5 data bits -> mem[0x05] unchanged, busy=0 and miso_oe=0 within 4 clk of cs rising, leds unchanged.
- BURST_EN=0 instance: write two words in one frame to 0x10 -> only mem[0x10] is updated; the second word is ignored; miso_pin=0 during HOLD.
- Reset mid-frame: assert reset during the 3rd address bit -> all outputs 0 immediately (asynchronously); a new frame after release operates normally; previously written memory data is retained.

Source files
------------

// File: rtl/spi_memory_burst.sv
// SPI mode-0 slave register memory with configurable widths and optional
// auto-incrementing burst access while chip select stays low.
module spi_memory_burst #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_EN   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic       miso_oe,
  output logic       busy,
  output logic [3:0] leds
);

  localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW    = $clog2(MAXW + 1);
  localparam int LW    = (DATA_WIDTH < 4) ? DATA_WIDTH : 4;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WRITE, S_READ, S_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sclk_sync_q, cs_sync_q;
  logic [1:0]              mosi_sync_q;
  logic [ADDR_WIDTH-1:0]   cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-2:0]   rx_q, rx_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    miso_q, miso_d;
  logic [3:0]              leds_q, leds_d;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic [DATA_WIDTH-1:0]   word_w;
  logic [ADDR_WIDTH-1:0]   addr_inc;

  // Index 1 is the synchronised level, index 2 its one-cycle-old copy.
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];
  assign word_w    = {rx_q, mosi_s};
  assign addr_inc  = addr_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cnt_q       <= '0;
      miso_q      <= 1'b0;
      leds_q      <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[1:0], sclk_pin};
      cs_sync_q   <= {cs_sync_q[1:0], cs_pin};
      mosi_sync_q <= {mosi_sync_q[0], mosi_pin};
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      leds_q      <= leds_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= word_w;
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    miso_d  = miso_q;
    leds_d  = leds_q;
    mem_we  = 1'b0;

    // Chip-select release overrides everything, including a word completing this cycle.
    if (cs_rise) begin
      state_d = S_IDLE;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_CMD;
            cnt_d   = '0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            if (cnt_q == CW'(ADDR_WIDTH)) begin
              addr_d = cmd_q;
              cnt_d  = '0;
              if (mosi_s) begin
                state_d = S_READ;
                tx_d    = mem_q[cmd_q];
                miso_d  = 1'b0;
              end else begin
                state_d = S_WRITE;
              end
            end else begin
              cmd_d = {cmd_q[ADDR_WIDTH-2:0], mosi_s};
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (sclk_rise) begin
            rx_d = word_w[DATA_WIDTH-2:0];
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
              mem_we = 1'b1;
              leds_d = 4'(word_w[LW-1:0]);
              if (BURST_EN != 0) begin
                addr_d = addr_inc;
                cnt_d  = '0;
              end else begin
                state_d = S_HOLD;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_READ: begin
          // cnt_q counts bits already presented on miso.
          if (sclk_fall && (cnt_q < CW'(DATA_WIDTH))) begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + 1'b1;
          end else if (sclk_rise && (cnt_q == CW'(DATA_WIDTH))) begin
            if (BURST_EN != 0) begin
              addr_d = addr_inc;
              tx_d   = mem_q[addr_inc];
              cnt_d  = '0;
            end else begin
              state_d = S_HOLD;
              miso_d  = 1'b0;
            end
          end
        end
        S_HOLD: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign miso_oe  = (state_q == S_READ);
  assign miso_pin = miso_oe & miso_q;
  assign leds     = leds_q;

endmodule

// File: tb/tb_spi_memory_burst.sv
// Randomised self-checking bench: a burst and a non-burst instance are driven
// through SPI frames and compared against an array-based memory model.
module tb_spi_memory_burst;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 128;
  localparam int HALF  = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic sel = 1'b0;

  logic sclk_a, cs_a, mosi_a, miso_a, oe_a, busy_a;
  logic sclk_b, cs_b, mosi_b, miso_b, oe_b, busy_b;
  logic [3:0] leds_a, leds_b;
  logic miso_s, oe_s, busy_s;
  logic [3:0] leds_s;

  assign sclk_a = sel ? 1'b0 : sclk;
  assign cs_a   = sel ? 1'b1 : cs;
  assign mosi_a = sel ? 1'b0 : mosi;
  assign sclk_b = sel ? sclk : 1'b0;
  assign cs_b   = sel ? cs : 1'b1;
  assign mosi_b = sel ? mosi : 1'b0;
  assign miso_s = sel ? miso_b : miso_a;
  assign oe_s   = sel ? oe_b : oe_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign leds_s = sel ? leds_b : leds_a;

  always #5 clk = ~clk;

  spi_memory_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_EN(1)) u_dut_a (
    .clk(clk), .reset(reset), .sclk_pin(sclk_a), .cs_pin(cs_a), .mosi_pin(mosi_a),
    .miso_pin(miso_a), .miso_oe(oe_a), .busy(busy_a), .leds(leds_a)
  );

  spi_memory_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_EN(0)) u_dut_b (
    .clk(clk), .reset(reset), .sclk_pin(sclk_b), .cs_pin(cs_b), .mosi_pin(mosi_b),
    .miso_pin(miso_b), .miso_oe(oe_b), .busy(busy_b), .leds(leds_b)
  );

  logic [7:0] mem_m [2][DEPTH];
  bit         vld_m [2][DEPTH];
  logic [3:0] leds_m [2];
  logic [7:0] wbuf [4];
  logic [7:0] rbuf [4];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic b, output logic s);
    mosi = b;
    wait_clk(HALF);
    s = miso_s;
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  task automatic send_cmd(input int a, input logic rw);
    logic s;
    cs = 1'b0;
    wait_clk(HALF);
    for (int i = AW - 1; i >= 0; i--) xfer(a[i], s);
    xfer(rw, s);
  endtask

  task automatic end_frame();
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(8);
    chk("idle_busy", int'(busy_s), 0);
  endtask

  // part = number of bits sent in the last word (0 = whole word)
  task automatic spi_write(input int a, input int n, input int part);
    logic s;
    int nb;
    send_cmd(a, 1'b0);
    for (int w = 0; w < n; w++) begin
      nb = (w == n - 1 && part != 0) ? part : DW;
      for (int b = 0; b < nb; b++) xfer(wbuf[w][DW-1-b], s);
    end
    end_frame();
  endtask

  task automatic model_write(input int a, input int n, input int part);
    int done;
    int ad;
    done = (part != 0) ? n - 1 : n;
    if (sel && done > 1) done = 1;
    for (int i = 0; i < done; i++) begin
      ad = (a + i) % DEPTH;
      mem_m[sel][ad] = wbuf[i];
      vld_m[sel][ad] = 1'b1;
      leds_m[sel]    = wbuf[i][3:0];
    end
  endtask

  task automatic spi_read(input int a, input int n);
    logic s;
    send_cmd(a, 1'b1);
    chk("read_oe", int'(oe_s), 1);
    for (int w = 0; w < n; w++) begin
      rbuf[w] = '0;
      for (int b = 0; b < DW; b++) begin
        xfer(1'($urandom_range(0, 1)), s);
        rbuf[w][DW-1-b] = s;
      end
    end
    end_frame();
  endtask

  task automatic check_read(input string tag, input int a, input int n);
    int ad;
    for (int w = 0; w < n; w++) begin
      ad = (a + w) % DEPTH;
      if (sel && w > 0) chk({tag, "_hold"}, int'(rbuf[w]), 0);
      else if (vld_m[sel][ad]) chk(tag, int'(rbuf[w]), int'(mem_m[sel][ad]));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic s;
    int seen, a, n, part;
    logic [15:0] pat;

    leds_m[0] = '0;
    leds_m[1] = '0;
    wait_clk(3);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_oe_a", int'(oe_a), 0);
    chk("rst_miso_a", int'(miso_a), 0);
    chk("rst_leds_a", int'(leds_a), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    reset = 1'b0;
    wait_clk(4);

    // single writes and reads
    sel = 1'b0;
    wbuf[0] = 8'hF0; spi_write('h6D, 1, 0); model_write('h6D, 1, 0);
    chk("leds_w1", int'(leds_a), int'(leds_m[0]));
    wbuf[0] = 8'h0F; spi_write('h0A, 1, 0); model_write('h0A, 1, 0);
    chk("leds_w2", int'(leds_a), 'hF);
    spi_read('h6D, 1); chk("rd_6d", int'(rbuf[0]), 'hF0);
    spi_read('h0A, 1); chk("rd_0a", int'(rbuf[0]), 'h0F);

    // sclk activity with cs high
    seen = 0;
    pat = 16'b1101101_0_01010101;
    for (int i = 15; i >= 0; i--) begin
      mosi = pat[i];
      for (int k = 0; k < HALF; k++) begin @(negedge clk); if (busy_a) seen = 1; end
      sclk = 1'b1;
      for (int k = 0; k < HALF; k++) begin @(negedge clk); if (busy_a) seen = 1; end
      sclk = 1'b0;
    end
    chk("cs_high_busy", seen, 0);
    spi_read('h6D, 1); chk("cs_high_rd", int'(rbuf[0]), 'hF0);

    // burst with wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    spi_write('h7E, 3, 0); model_write('h7E, 3, 0);
    spi_read('h7E, 3);
    chk("burst_7e", int'(rbuf[0]), 'h11);
    chk("burst_7f", int'(rbuf[1]), 'h22);
    chk("burst_00", int'(rbuf[2]), 'h33);

    // aborted write and aborted read
    wbuf[0] = 8'hA5; spi_write('h05, 1, 0); model_write('h05, 1, 0);
    send_cmd('h05, 1'b0);
    for (int b = 0; b < 5; b++) xfer(1'b1, s);
    chk("abort_busy_pre", int'(busy_a), 1);
    cs = 1'b1;
    wait_clk(4);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_oe", int'(oe_a), 0);
    wait_clk(4);
    chk("abort_leds", int'(leds_a), 'h5);
    spi_read('h05, 1); chk("abort_mem", int'(rbuf[0]), 'hA5);
    send_cmd('h6D, 1'b1);
    for (int b = 0; b < 3; b++) xfer(1'b0, s);
    cs = 1'b1;
    wait_clk(4);
    chk("rabort_oe", int'(oe_a), 0);
    chk("rabort_miso", int'(miso_a), 0);
    wait_clk(4);

    // non-burst instance
    sel = 1'b1;
    wbuf[0] = 8'h77; spi_write('h11, 1, 0); model_write('h11, 1, 0);
    wbuf[0] = 8'h9C; wbuf[1] = 8'h42;
    spi_write('h10, 2, 0); model_write('h10, 2, 0);
    chk("nb_leds", int'(leds_b), 'hC);
    spi_read('h10, 2);
    chk("nb_rd10", int'(rbuf[0]), 'h9C);
    chk("nb_hold_miso", int'(rbuf[1]), 0);
    spi_read('h11, 1); chk("nb_rd11", int'(rbuf[0]), 'h77);

    // reset in the middle of the third address bit
    sel = 1'b0;
    cs = 1'b0;
    wait_clk(HALF);
    xfer(1'b1, s); xfer(1'b0, s);
    mosi = 1'b1;
    wait_clk(HALF);
    sclk = 1'b1;
    wait_clk(4);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy_a", int'(busy_a), 0);
    chk("arst_oe_a", int'(oe_a), 0);
    chk("arst_miso_a", int'(miso_a), 0);
    chk("arst_leds_a", int'(leds_a), 0);
    chk("arst_leds_b", int'(leds_b), 0);
    leds_m[0] = '0;
    leds_m[1] = '0;
    sclk = 1'b0;
    cs = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    spi_read('h6D, 1); chk("arst_retain", int'(rbuf[0]), 'hF0);
    wbuf[0] = 8'h5A; spi_write('h20, 1, 0); model_write('h20, 1, 0);
    spi_read('h20, 1); chk("arst_new", int'(rbuf[0]), 'h5A);

    // randomised frames on both instances
    for (int f = 0; f < 32; f++) begin
      sel  = (f >= 24);
      a    = $urandom_range(0, DEPTH - 1);
      n    = $urandom_range(1, 4);
      if ($urandom_range(0, 2) != 0) begin
        for (int w = 0; w < 4; w++) wbuf[w] = 8'($urandom_range(0, 255));
        part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : 0;
        spi_write(a, n, part);
        model_write(a, n, part);
        chk("rnd_leds", int'(leds_s), int'(leds_m[sel]));
      end else begin
        spi_read(a, n);
        check_read("rnd_rd", a, n);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
